// File: rtl/outer1bits_expand.sv
// Bit-serial fill-mask rebuilder: turns one-hot left/right edge markers back into
// the contiguous run of ones between them. OUTER1BITS_EXPAND_BACKPRESSURE_EN adds data_ready_i.
module outer1bits_expand #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_val_i,
    input  logic [WIDTH-1:0] data_left_i,
    input  logic [WIDTH-1:0] data_right_i,
`ifdef OUTER1BITS_EXPAND_BACKPRESSURE_EN
    input  logic             data_ready_i,
`endif
    output logic             data_ready_o,
    output logic             data_val_o,
    output logic [WIDTH-1:0] data_o,
    output logic             error_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             inside_q, inside_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] right_q, right_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_out_q, err_out_d;
    logic             inside_next;
    logic             word_ok;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    assign word_ok = is_onehot(data_left_i) && is_onehot(data_right_i)
                     && (data_left_i >= data_right_i);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        inside_d    = inside_q;
        left_d      = left_q;
        right_d     = right_q;
        mask_d      = mask_q;
        err_d       = err_q;
        data_d      = data_q;
        err_out_d   = err_out_q;
        inside_next = inside_q | left_q[idx_q];

        case (state_q)
            IDLE: begin
                if (data_val_i) begin
                    state_d  = SCAN;
                    inside_d = 1'b0;
                    mask_d   = '0;
                    if (word_ok) begin
                        left_d  = data_left_i;
                        right_d = data_right_i;
                        idx_d   = IDX_W'(WIDTH - 1);
                        err_d   = 1'b0;
                    end else begin
                        // Zero/malformed words run a single blank scan step at bit 0,
                        // which yields an all-zero mask one edge later.
                        left_d  = '0;
                        right_d = '0;
                        idx_d   = '0;
                        err_d   = (data_left_i != '0) || (data_right_i != '0);
                    end
                end
            end
            SCAN: begin
                mask_d[idx_q] = inside_next;
                inside_d      = inside_next & ~right_q[idx_q];
                if (idx_q == '0) begin
                    state_d   = DONE;
                    data_d    = mask_d;
                    err_out_d = err_q;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
`ifdef OUTER1BITS_EXPAND_BACKPRESSURE_EN
                if (data_ready_i) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            inside_q  <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            inside_q  <= inside_d;
            left_q    <= left_d;
            right_q   <= right_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            data_q    <= data_d;
            err_out_q <= err_out_d;
        end
    end

    assign data_ready_o = (state_q == IDLE);
    assign data_val_o   = (state_q == DONE);
    assign data_o       = data_q;
    assign error_o      = err_out_q;

endmodule

// File: tb/tb_outer1bits_expand.sv
// Directed bench for outer1bits_expand (WIDTH=4) with a fill-mask reference model,
// a latency-aware scoreboard and a round-trip outermost-ones check.
module tb_outer1bits_expand;

    localparam int W = 4;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         data_val_i = 1'b0;
    logic [W-1:0] data_left_i = '0;
    logic [W-1:0] data_right_i = '0;
    logic         data_ready_o;
    logic         data_val_o;
    logic [W-1:0] data_o;
    logic         error_o;
    logic         bp_ready = 1'b1;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int edge_cnt  = 0;
    int last_accept = -1;

    typedef struct {
        logic [W-1:0] mask;
        logic         err;
        int           due;
        logic [W-1:0] l;
        logic [W-1:0] r;
        bit           seen;
    } exp_t;
    exp_t q[$];

    outer1bits_expand #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_val_i  (data_val_i),
        .data_left_i (data_left_i),
        .data_right_i(data_right_i),
`ifdef OUTER1BITS_EXPAND_BACKPRESSURE_EN
        .data_ready_i(bp_ready),
`endif
        .data_ready_o(data_ready_o),
        .data_val_o  (data_val_o),
        .data_o      (data_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    endtask

    // Reference: mask covers bit positions from the left marker down to the right marker.
    function automatic void model(input logic [W-1:0] l, input logic [W-1:0] r,
                                  output logic [W-1:0] mask, output logic err);
        int pl = -1;
        int pr = -1;
        mask = '0;
        err  = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (l[i]) pl = i;
            if (r[i]) pr = i;
        end
        if (l == '0 && r == '0) return;
        if ($countones(l) != 1 || $countones(r) != 1 || pl < pr) begin
            err = 1'b1;
            return;
        end
        for (int i = 0; i < W; i++) mask[i] = (i <= pl) && (i >= pr);
    endfunction

    function automatic void detect(input logic [W-1:0] m, output logic [W-1:0] l,
                                   output logic [W-1:0] r);
        l = '0;
        r = '0;
        for (int i = 0; i < W; i++) if (m[i]) l = W'(1) << i;
        for (int i = W - 1; i >= 0; i--) if (m[i]) r = W'(1) << i;
    endfunction

    // Scoreboard: every cycle outside reset.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (q.size() > 0 && q[0].seen && !data_val_o) void'(q.pop_front());
            if (data_val_o) begin
`ifdef OUTER1BITS_EXPAND_BACKPRESSURE_EN
                if (q.size() == 0) begin
`else
                if (q.size() == 0 || q[0].seen) begin
`endif
                    chk("unexpected_valid", 32'(data_val_o), 32'd0);
                end else begin
                    chk("data_o", 32'(data_o), 32'(q[0].mask));
                    chk("error_o", 32'(error_o), 32'(q[0].err));
                    if (!q[0].seen) begin
                        chk("valid_latency", 32'(edge_cnt), 32'(q[0].due));
                        if (!q[0].err && q[0].mask != '0) begin
                            logic [W-1:0] dl, dr;
                            detect(data_o, dl, dr);
                            chk("roundtrip", 32'({dl, dr}), 32'({q[0].l, q[0].r}));
                        end
                    end
                    q[0].seen = 1'b1;
                end
            end else if (q.size() > 0 && !q[0].seen && edge_cnt > q[0].due) begin
                chk("missing_valid", 32'(edge_cnt), 32'(q[0].due));
                void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input bit use_lit,
                        input logic [W-1:0] lit_mask, input logic lit_err, input bit chk_gap);
        int waited = 0;
        exp_t e;
        logic [W-1:0] m;
        logic er;
        @(negedge clk_i);
        data_val_i   = 1'b1;
        data_left_i  = l;
        data_right_i = r;
        while (!data_ready_o && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        if (!data_ready_o) begin
            chk("accept_timeout", 32'(data_ready_o), 32'd1);
            return;
        end
        model(l, r, m, er);
        if (use_lit) begin
            chk("model_vs_literal", 32'({m, er}), 32'({lit_mask, lit_err}));
            m  = lit_mask;
            er = lit_err;
        end
        e.mask = m;
        e.err  = er;
        e.l    = l;
        e.r    = r;
        e.seen = 1'b0;
        e.due  = edge_cnt + 1 + ((er || (l == '0 && r == '0)) ? 1 : W);
        if (chk_gap && last_accept >= 0) chk("throughput_gap", 32'(edge_cnt + 1 - last_accept), 32'(W + 2));
        last_accept = edge_cnt + 1;
        q.push_back(e);
        @(posedge clk_i);
    endtask

    task automatic drain();
        int waited = 0;
        @(negedge clk_i);
        data_val_i = 1'b0;
        while (q.size() > 0 && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(data_ready_o), 32'd1);
        chk({tag, "_val"}, 32'(data_val_o), 32'd0);
        chk({tag, "_data"}, 32'(data_o), 32'd0);
        chk({tag, "_err"}, 32'(error_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] m;
        logic er;
        #2;
        chk_reset_vals("reset");
        model(4'b0100, 4'b0001, m, er);
        chk("model_0100_0001", 32'({m, er}), 32'({4'b0111, 1'b0}));
        model(4'b0001, 4'b0100, m, er);
        chk("model_0001_0100", 32'(er), 32'd1);
        model(4'b1000, 4'b1000, m, er);
        chk("model_1000_1000", 32'(m), 32'(4'b1000));
        @(negedge clk_i);
        rst_i = 1'b0;

        send(4'b0100, 4'b0001, 1, 4'b0111, 1'b0, 0); drain();
        send(4'b1000, 4'b0010, 1, 4'b1110, 1'b0, 0); drain();
        send(4'b1000, 4'b1000, 1, 4'b1000, 1'b0, 0); drain();
        send(4'b0000, 4'b0000, 1, 4'b0000, 1'b0, 0); drain();
        send(4'b0001, 4'b0100, 1, 4'b0000, 1'b1, 0); drain();
        send(4'b0110, 4'b0010, 1, 4'b0000, 1'b1, 0); drain();
        send(4'b0000, 4'b0010, 1, 4'b0000, 1'b1, 0); drain();

        // Busy: keep presenting new words while the first one scans.
        send(4'b1000, 4'b0010, 1, 4'b1110, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            data_left_i  = 4'b0001 << i;
            data_right_i = 4'b0001;
            chk("busy_ready_low", 32'(data_ready_o), 32'd0);
        end
        drain();

        // Reset two cycles into a scan drops the word.
        send(4'b1000, 4'b0001, 1, 4'b1111, 1'b0, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        data_val_i = 1'b0;
        q.delete();
        rst_i = 1'b1;
        #1;
        chk_reset_vals("midscan_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        send(4'b0010, 4'b0001, 1, 4'b0011, 1'b0, 0); drain();

        // Every legal pair, back to back.
        last_accept = -1;
        for (int i = 0; i < W; i++)
            for (int j = 0; j <= i; j++)
                send(W'(1) << i, W'(1) << j, 0, '0, 1'b0, 1);
        drain();

`ifdef OUTER1BITS_EXPAND_BACKPRESSURE_EN
        bp_ready = 1'b0;
        send(4'b1000, 4'b0100, 1, 4'b1100, 1'b0, 0);
        @(negedge clk_i);
        data_left_i  = 4'b0010;
        data_right_i = 4'b0001;
        for (int k = 0; k < 20 && !data_val_o; k++) @(negedge clk_i);
        chk("bp_valid_seen", 32'(data_val_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("bp_hold_val", 32'(data_val_o), 32'd1);
            chk("bp_hold_data", 32'(data_o), 32'(4'b1100));
            chk("bp_ready_low", 32'(data_ready_o), 32'd0);
        end
        #1;
        bp_ready   = 1'b1;
        data_val_i = 1'b0;
        @(negedge clk_i);
        chk("bp_release_idle", 32'({data_ready_o, data_val_o}), 32'(2'b10));
        drain();
`endif

        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
